chaos_sbox_gen: RTL and testbench

CHAOS_SBOX_GEN -- requirements
Module: chaos_sbox_gen

---
 rtl/chaos_pkg.sv | 25 ++
 rtl/chaos_logistic_step.sv | 25 ++
 rtl/chaos_sbox_gen.sv | 157 +++++++++++++++
 tb/tb_chaos_sbox_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_pkg.sv
// Shared definitions for the chaotic S-box generator: FSM states, map arithmetic
// widths and the zero-substitution rule applied to every logistic-map output.
package chaos_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_FILL,
      ST_DONE
   } sbox_state_t;

   // Coefficient r is Q2.FRAC_W, so it carries two integer bits above the fraction.
   localparam int COEF_INT_BITS = 2;
   localparam int ZSUB_W        = 64;

   function automatic int map_prod_w(input int fracW);
      return 3 * fracW + COEF_INT_BITS + 1;
   endfunction

   // A collapsed state of zero would stall the map forever; restart from all ones.
   function automatic logic [ZSUB_W-1:0] zero_subst(input logic [ZSUB_W-1:0] i_x);
      return (i_x == '0) ? '1 : i_x;
   endfunction

endpackage

// File: rtl/chaos_logistic_step.sv
// One combinational logistic-map step x' = r*x*(1-x) in unsigned fixed point,
// with the zero-substitution rule applied to the truncated result.
module chaos_logistic_step
   import chaos_pkg::*;
#(
   parameter int FRAC_W = 16
)
(
   input  logic [FRAC_W-1:0] i_x,
   input  logic [FRAC_W+1:0] i_r,
   output logic [FRAC_W-1:0] o_x
);

   localparam int PROD_W = map_prod_w(FRAC_W);

   logic [PROD_W-1:0] w_comp;
   logic [PROD_W-1:0] w_prod;
   logic [FRAC_W-1:0] w_raw;

   assign w_comp = (PROD_W'(1) << FRAC_W) - PROD_W'(i_x);
   assign w_prod = PROD_W'(i_r) * PROD_W'(i_x) * w_comp;
   assign w_raw  = FRAC_W'(w_prod >> (2 * FRAC_W));
   assign o_x    = FRAC_W'(zero_subst(ZSUB_W'(w_raw)));

endmodule

// File: rtl/chaos_sbox_gen.sv
// Builds an S-box permutation from logistic-map candidates, topping up by ascending
// fill when the iteration budget runs out. Optional inverse table: CHAOS_SBOX_INVERSE_EN.
module chaos_sbox_gen
   import chaos_pkg::*;
#(
   parameter int SBOX_BITS = 8,
   parameter int FRAC_W    = 16,
   parameter int MAX_ITER  = 4096
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [FRAC_W-1:0]    seed,
   input  logic [FRAC_W+1:0]    r_coef,
   output logic                 busy,
   output logic                 done_sbox,
   output logic                 fallback,
   input  logic [SBOX_BITS-1:0] rd_addr,
   output logic [SBOX_BITS-1:0] rd_data
`ifdef CHAOS_SBOX_INVERSE_EN
   ,
   input  logic [SBOX_BITS-1:0] inv_rd_addr,
   output logic [SBOX_BITS-1:0] inv_rd_data
`endif
);

   localparam int N      = 1 << SBOX_BITS;
   localparam int CNT_W  = SBOX_BITS + 1;
   localparam int ITER_W = $clog2(MAX_ITER + 1);

   sbox_state_t          r_state;
   sbox_state_t          w_stateNext;
   logic [FRAC_W-1:0]    r_x;
   logic [FRAC_W-1:0]    w_xNext;
   logic [FRAC_W+1:0]    r_r;
   logic [N-1:0]         r_used;
   logic [CNT_W-1:0]     r_count;
   logic [CNT_W-1:0]     w_countNext;
   logic [ITER_W-1:0]    r_iterCnt;
   logic [SBOX_BITS-1:0] r_scan;
   logic [SBOX_BITS-1:0] w_cand;
   logic [SBOX_BITS-1:0] w_wrVal;
   logic                 w_wrEn;
   logic                 w_accept;
   logic                 w_iterLast;
   logic                 w_full;
   logic                 r_fallback;
   logic [SBOX_BITS-1:0] r_sbox [N];

   chaos_logistic_step #(.FRAC_W(FRAC_W)) u_step (
      .i_x (r_x),
      .i_r (r_r),
      .o_x (w_xNext)
   );

   assign w_cand      = w_xNext[FRAC_W-1 -: SBOX_BITS];
   assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_iterLast  = (r_iterCnt == ITER_W'(MAX_ITER - 1));
   assign w_countNext = r_count + CNT_W'(w_wrEn);
   assign w_full      = (w_countNext == CNT_W'(N));
   assign busy        = (r_state == ST_ITER) || (r_state == ST_FILL);
   assign done_sbox   = (r_state == ST_DONE);
   assign fallback    = r_fallback;

   // A value is appended only if it has never been placed, which keeps S a permutation.
   always_comb begin
      w_wrEn  = 1'b0;
      w_wrVal = '0;
      case (r_state)
         ST_ITER: begin
            w_wrVal = w_cand;
            w_wrEn  = !r_used[w_cand];
         end
         ST_FILL: begin
            w_wrVal = r_scan;
            w_wrEn  = !r_used[r_scan];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start) w_stateNext = ST_ITER;
         ST_ITER: begin
            if (w_full)          w_stateNext = ST_DONE;
            else if (w_iterLast) w_stateNext = ST_FILL;
         end
         ST_FILL: if (w_full) w_stateNext = ST_DONE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_stateNext;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_x        <= '0;
         r_r        <= '0;
         r_used     <= '0;
         r_count    <= '0;
         r_iterCnt  <= '0;
         r_scan     <= '0;
         r_fallback <= 1'b0;
      end else if (w_accept) begin
         r_x        <= seed;
         r_r        <= r_coef;
         r_used     <= '0;
         r_count    <= '0;
         r_iterCnt  <= '0;
         r_scan     <= '0;
         r_fallback <= 1'b0;
      end else begin
         if (w_wrEn) begin
            r_used[w_wrVal] <= 1'b1;
            r_count         <= w_countNext;
         end
         if (r_state == ST_ITER) begin
            r_x       <= w_xNext;
            r_iterCnt <= r_iterCnt + ITER_W'(1);
         end
         if (r_state == ST_FILL) begin
            r_scan <= r_scan + SBOX_BITS'(1);
            if (w_full) r_fallback <= 1'b1;
         end
      end
   end

   // Table storage is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (rst && w_wrEn) r_sbox[r_count[SBOX_BITS-1:0]] <= w_wrVal;
   end

   always_ff @(posedge clk) begin
      if (!rst) rd_data <= '0;
      else      rd_data <= r_sbox[rd_addr];
   end

`ifdef CHAOS_SBOX_INVERSE_EN
   logic [SBOX_BITS-1:0] r_inv [N];

   always_ff @(posedge clk) begin
      if (rst && w_wrEn) r_inv[w_wrVal] <= r_count[SBOX_BITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) inv_rd_data <= '0;
      else      inv_rd_data <= r_inv[inv_rd_addr];
   end
`endif

endmodule

// File: tb/tb_chaos_sbox_gen.sv
// Bench for chaos_sbox_gen: a default 256-entry instance and a 16-entry instance with a
// tiny iteration budget, both compared against an arithmetic model of the generation rules.
module tb_chaos_sbox_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, startS;
   logic [15:0] seed, seedS;
   logic [17:0] rCoef, rCoefS;
   logic        busy, busyS;
   logic        doneSbox, doneS;
   logic        fallback, fallbackS;
   logic [7:0]  rdAddr, rdData;
   logic [3:0]  rdAddrS, rdDataS;
`ifdef CHAOS_SBOX_INVERSE_EN
   logic [7:0]  invAddr, invData;
   logic [3:0]  invAddrS, invDataS;
`endif

   int checks = 0;
   int errors = 0;
   int expS [256];
   bit expFallback;

   always #5 clk = ~clk;

   chaos_sbox_gen #(.SBOX_BITS(8), .FRAC_W(16), .MAX_ITER(4096)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .seed        (seed),
      .r_coef      (rCoef),
      .busy        (busy),
      .done_sbox   (doneSbox),
      .fallback    (fallback),
      .rd_addr     (rdAddr),
      .rd_data     (rdData)
`ifdef CHAOS_SBOX_INVERSE_EN
      ,
      .inv_rd_addr (invAddr),
      .inv_rd_data (invData)
`endif
   );

   chaos_sbox_gen #(.SBOX_BITS(4), .FRAC_W(16), .MAX_ITER(2)) dutSmall (
      .clk         (clk),
      .rst         (rst),
      .start       (startS),
      .seed        (seedS),
      .r_coef      (rCoefS),
      .busy        (busyS),
      .done_sbox   (doneS),
      .fallback    (fallbackS),
      .rd_addr     (rdAddrS),
      .rd_data     (rdDataS)
`ifdef CHAOS_SBOX_INVERSE_EN
      ,
      .inv_rd_addr (invAddrS),
      .inv_rd_data (invDataS)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference generator: plain integer arithmetic on the map, then ascending fill.
   task automatic modelGen(input int sb, input int maxIter, input longint sd, input longint rc);
      longint x;
      int     n, cnt, c;
      bit     used [256];
      foreach (used[i]) used[i] = 1'b0;
      x   = sd;
      n   = 1 << sb;
      cnt = 0;
      for (int it = 0; it < maxIter && cnt < n; it++) begin
         x = ((rc * x * (65536 - x)) >> 32) % 65536;
         if (x == 0) x = 65535;
         c = int'(x >> (16 - sb));
         if (!used[c]) begin
            used[c]   = 1'b1;
            expS[cnt] = c;
            cnt++;
         end
      end
      expFallback = (cnt < n);
      for (int v = 0; v < n; v++) begin
         if (!used[v]) begin
            used[v]   = 1'b1;
            expS[cnt] = v;
            cnt++;
         end
      end
   endtask

   task automatic applyStimulus(input int which, input logic [15:0] sd, input logic [17:0] rc);
      @(negedge clk);
      if (which == 0) begin
         seed = sd; rCoef = rc; start = 1'b1;
      end else begin
         seedS = sd; rCoefS = rc; startS = 1'b1;
      end
      @(negedge clk);
      start  = 1'b0;
      startS = 1'b0;
   endtask

   task automatic waitDone(input int which, input int limit, input string tag);
      int cycles = 1;
      while (((which == 0) ? doneSbox : doneS) !== 1'b1 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput(tag, 32'(((which == 0) ? doneSbox : doneS) === 1'b1), 32'd1);
   endtask

   task automatic checkTable(input int which, input string tag);
      int         n;
      int         distinct;
      bit         seen [256];
      logic [7:0] obs;
      foreach (seen[i]) seen[i] = 1'b0;
      n        = (which == 0) ? 256 : 16;
      distinct = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (which == 0) rdAddr = 8'(i);
         else            rdAddrS = 4'(i);
         @(negedge clk);
         obs = (which == 0) ? rdData : {4'b0, rdDataS};
         checkOutput(tag, 32'(obs), 32'(expS[i]));
         if (!seen[obs]) begin
            seen[obs] = 1'b1;
            distinct++;
         end
      end
      checkOutput({tag, "_perm"}, 32'(distinct), 32'(n));
`ifdef CHAOS_SBOX_INVERSE_EN
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (which == 0) invAddr = 8'(expS[i]);
         else            invAddrS = 4'(expS[i]);
         @(negedge clk);
         obs = (which == 0) ? invData : {4'b0, invDataS};
         checkOutput({tag, "_inv"}, 32'(obs), 32'(i));
      end
`endif
   endtask

   task automatic fullRun(input int which, input logic [15:0] sd, input logic [17:0] rc, input string tag);
      if (which == 0) modelGen(8, 4096, longint'(sd), longint'(rc));
      else            modelGen(4, 2, longint'(sd), longint'(rc));
      applyStimulus(which, sd, rc);
      waitDone(which, (which == 0) ? 4096 + 256 + 2 : 20, {tag, "_done"});
      checkOutput({tag, "_fallback"}, 32'((which == 0) ? fallback : fallbackS), 32'(expFallback));
      checkTable(which, {tag, "_tab"});
   endtask

   initial begin
      logic [15:0] sdA, sdB;
      logic [17:0] rcA;
      rst = 1'b0; start = 1'b0; startS = 1'b0;
      seed = '0; seedS = '0; rCoef = '0; rCoefS = '0;
      rdAddr = '0; rdAddrS = '0;
`ifdef CHAOS_SBOX_INVERSE_EN
      invAddr = '0; invAddrS = '0;
`endif
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(doneSbox), 32'd0);
      checkOutput("rst_fallback", 32'(fallback), 32'd0);
      checkOutput("rst_rddata", 32'(rdData), 32'd0);
      checkOutput("rst_small_done", 32'(doneS), 32'd0);
      checkOutput("rst_small_rddata", 32'(rdDataS), 32'd0);
      rst = 1'b1;

      $display("[TB] reference seed run");
      fullRun(0, 16'h3A7F, 18'h3_F000, "seed3a7f");

      $display("[TB] zero seed run");
      fullRun(0, 16'h0000, 18'h3_F000, "seed0");
      @(negedge clk);
      rdAddr = 8'd0;
      @(negedge clk);
      checkOutput("seed0_first", 32'(rdData), 32'h0000_00FF);

      $display("[TB] random runs");
      for (int k = 0; k < 2; k++) begin
         sdA = 16'($urandom_range(1, 65535));
         rcA = 18'($urandom_range(18'h3_0000, 18'h3_FFFF));
         fullRun(0, sdA, rcA, "rand");
      end

      $display("[TB] reset during generation");
      sdA = 16'($urandom_range(1, 65535));
      applyStimulus(0, sdA, 18'h3_F000);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(doneSbox), 32'd0);
      checkOutput("midrst_fallback", 32'(fallback), 32'd0);
      checkOutput("midrst_rddata", 32'(rdData), 32'd0);
      rst = 1'b1;
      fullRun(0, sdA, 18'h3_F000, "afterrst");

      $display("[TB] start while busy");
      sdA = 16'($urandom_range(1, 65535));
      sdB = sdA ^ 16'h5A5A;
      modelGen(8, 4096, longint'(sdA), longint'(18'h3_E000));
      applyStimulus(0, sdA, 18'h3_E000);
      repeat (5) @(negedge clk);
      checkOutput("busy_mid", 32'(busy), 32'd1);
      seed = sdB; rCoef = 18'h3_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(0, 4096 + 256 + 2, "ignstart_done");
      checkOutput("ignstart_fallback", 32'(fallback), 32'(expFallback));
      checkTable(0, "ignstart_tab");

      $display("[TB] small instance fallback runs");
      fullRun(1, 16'h3A7F, 18'h3_F000, "small");
      fullRun(1, 16'($urandom_range(0, 65535)), 18'($urandom_range(18'h3_0000, 18'h3_FFFF)), "smallrand");
      checkOutput("small_fallback_level", 32'(fallbackS && doneS), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
